// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the sliced, pipelined adder/subtractor.
package pipelined_adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  // Widest result the clamp helper can describe; callers narrow it to N bits.
  localparam int SAT_MAX_W = 512;

  // Clamp pattern for an n-bit signed result: most negative if sign, else most positive.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int n);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i + 1 < n)       v[i] = ~sign;
      else if (i + 1 == n) v[i] = sign;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_add_slice.sv
// One W-bit carry-chain slice with its stage register (load enable, async clear).
module pipe_add_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_sum,
  output logic         o_c
);

  logic [W:0]   w_add;
  logic [W-1:0] r_sum;
  logic         r_c;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_c   <= 1'b0;
    end else if (i_en) begin
      r_sum <= w_add[W-1:0];
      r_c   <= w_add[W];
    end
  end

  assign o_sum = r_sum;
  assign o_c   = r_c;

endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/sub split into STAGES carry slices, one per pipeline stage, with a
// global-stall valid/ready handshake, signed overflow detection and optional saturation.
module pipelined_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Op,
  input  logic         Sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);
  import pipelined_adder_pkg::*;

  localparam int W = N / STAGES;

  op_e               w_op;
  logic              w_adv;
  logic              w_cin_eff;
  logic [N-1:0]      w_beff;
  logic [N-1:0]      w_raw;
  logic              w_ovf;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_sat;
  logic [STAGES-1:0] r_amsb;
  logic [STAGES-1:0] r_bmsb;
  logic [N-1:0]      r_a  [STAGES];
  logic [N-1:0]      r_b  [STAGES];
  logic [N-1:0]      r_lo [STAGES];

  logic [N-1:0]      w_a_src [STAGES];
  logic [N-1:0]      w_b_src [STAGES];
  logic [N-1:0]      w_done  [STAGES];
  logic [W-1:0]      w_sq    [STAGES];
  logic [STAGES-1:0] w_c_src;
  logic [STAGES-1:0] w_co;

  assign w_op      = op_e'(Op);
  assign w_beff    = (w_op == OP_SUB) ? ~B : B;
  assign w_cin_eff = (w_op == OP_SUB) ? ~Cin : Cin;
  assign w_adv     = !r_vld[STAGES-1] || out_ready;
  assign in_ready  = w_adv;

  // Remaining operand bits are kept right-aligned, so every stage consumes bits [W-1:0].
  always_comb begin
    w_a_src[0] = A;
    w_b_src[0] = w_beff;
    w_c_src[0] = w_cin_eff;
    for (int k = 1; k < STAGES; k++) begin
      w_a_src[k] = r_a[k-1];
      w_b_src[k] = r_b[k-1];
      w_c_src[k] = w_co[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_done[k]           = r_lo[k];
      w_done[k][k*W +: W] = w_sq[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_sat  <= '0;
      r_amsb <= '0;
      r_bmsb <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]  <= '0;
        r_b[k]  <= '0;
        r_lo[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld[0]  <= in_valid;
      r_sat[0]  <= Sat;
      r_amsb[0] <= A[N-1];
      r_bmsb[0] <= w_beff[N-1];
      r_lo[0]   <= '0;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_sat[k]  <= r_sat[k-1];
        r_amsb[k] <= r_amsb[k-1];
        r_bmsb[k] <= r_bmsb[k-1];
        r_lo[k]   <= w_done[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a_src[k] >> W;
        r_b[k] <= w_b_src[k] >> W;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipe_add_slice #(.W(W)) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_adv),
      .i_a   (w_a_src[k][W-1:0]),
      .i_b   (w_b_src[k][W-1:0]),
      .i_c   (w_c_src[k]),
      .o_sum (w_sq[k]),
      .o_c   (w_co[k])
    );
  end

  // Cout and Ovf always describe the unsaturated result.
  assign w_raw     = w_done[STAGES-1];
  assign w_ovf     = (r_amsb[STAGES-1] == r_bmsb[STAGES-1]) && (w_raw[N-1] != r_amsb[STAGES-1]);
  assign out_valid = r_vld[STAGES-1];
  assign Cout      = w_co[STAGES-1];
  assign Ovf       = w_ovf;
  assign Sum       = (r_sat[STAGES-1] && w_ovf) ? N'(sat_value(r_amsb[STAGES-1], N)) : w_raw;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks on an 8-bit/2-stage adder and a scoreboarded random run on a 32-bit/4-stage adder.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv8, ir8, cin8, op8, sat8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, sum8;

  logic        iv32, ir32, cin32, op32, sat32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, sum32;

  pipelined_adder #(.N(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .Cin(cin8), .Op(op8), .Sat(sat8), .out_valid(ov8), .out_ready(or8),
    .Sum(sum8), .Cout(co8), .Ovf(of8)
  );

  pipelined_adder #(.N(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .Cin(cin32), .Op(op32), .Sat(sat32), .out_valid(ov32), .out_ready(or32),
    .Sum(sum32), .Cout(co32), .Ovf(of32)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated transaction on the 8-bit adder; result must appear exactly two cycles later.
  task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic op, input logic sat,
                      input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; op8 = op; sat8 = sat; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    chk({tag, "_early"}, ov8, 1'b0);
    @(negedge clk);
    chk({tag, "_vld"}, ov8, 1'b1);
    chk(tag, {of8, co8, sum8}, {eo, ec, es});
  endtask

  function automatic logic [33:0] mdl32(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic op, input logic sat);
    longint ua, ub, sa, sb, ci, ur, sr;
    logic [31:0] s;
    logic co, ov;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ci = {63'd0, cin};
    if (op) begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      co = (ur >= 0);
    end else begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      co = (ur > 64'sd4294967295);
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    s  = ur[31:0];
    if (sat && ov) s = (sr < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {ov, co, s};
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF; corner[3] = 32'h8000_0000;
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  logic [7:0] bp_a [5] = '{8'h10, 8'h31, 8'h52, 8'h73, 8'h94};
  logic [7:0] bp_b [5] = '{8'h01, 8'h04, 8'h07, 8'h0A, 8'h0D};
  logic [7:0] bp_s [5] = '{8'h11, 8'h35, 8'h59, 8'h7D, 8'hA1};

  localparam int NTX = 10000;
  logic [33:0] q_exp [$];
  int          q_cyc [$];
  int          q_stl [$];

  initial begin
    int idx, oidx, stall_left, extra, cyc, stalls, sent, got, c0, s0;
    logic seen;
    logic [33:0] e;

    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; op8 = 0; sat8 = 0; or8 = 1;
    iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; op32 = 0; sat32 = 0; or32 = 1;
    #12;
    chk("rst_ovld", ov8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", co8, 1'b0);
    chk("rst_ovf", of8, 1'b0);
    chk("rst_inrdy", ir8, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    dir8("add_carry",  8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0);
    dir8("add_ovf",    8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    dir8("add_sat",    8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    dir8("sub_borrow", 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    dir8("sub_sat",    8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
    dir8("sub_bin",    8'h05, 8'h03, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    dir8("add_negsat", 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
    dir8("add_slice",  8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    // Backpressure: five back-to-back operands, out_ready low for 3 cycles at first result.
    idx = 0; oidx = 0; stall_left = 0; seen = 1'b0;
    for (int c = 0; c < 40 && oidx < 5; c++) begin
      @(negedge clk);
      if (ov8 && !seen) begin seen = 1'b1; stall_left = 3; end
      or8 = (stall_left == 0);
      if (idx < 5) begin
        iv8 = 1'b1; a8 = bp_a[idx]; b8 = bp_b[idx]; cin8 = 0; op8 = 0; sat8 = 0;
      end else iv8 = 1'b0;
      #1;
      if (stall_left > 0) begin
        chk("bp_inrdy", ir8, 1'b0);
        chk("bp_hold", sum8, bp_s[0]);
        stall_left--;
      end
      if (ov8 && or8) begin
        chk("bp_out", {of8, sum8}, {1'b0, bp_s[oidx]});
        oidx++;
      end
      if (iv8 && ir8) idx++;
    end
    iv8 = 1'b0; or8 = 1'b1;
    chk("bp_count", oidx, 5);
    extra = 0;
    repeat (4) begin @(negedge clk); if (ov8) extra++; end
    chk("bp_dup", extra, 0);

    // Reset with two results in flight.
    @(negedge clk);
    a8 = 8'h22; b8 = 8'h11; cin8 = 0; op8 = 0; sat8 = 0; iv8 = 1'b1;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h05;
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b0;
    chk("rmid_pre", {ov8, sum8}, {1'b1, 8'h33});
    rst_n = 1'b0;
    #1;
    chk("rmid_ovld", ov8, 1'b0);
    chk("rmid_sum", sum8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; or8 = 1'b1;
    extra = 0;
    repeat (6) begin @(negedge clk); if (ov8) extra++; end
    chk("rmid_stale", extra, 0);

    // Random regression on the 32-bit, 4-stage instance.
    cyc = 0; stalls = 0; sent = 0; got = 0;
    while ((sent < NTX || got < sent) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      or32 = ($urandom_range(0, 3) != 0);
      if (sent < NTX && $urandom_range(0, 3) != 0) begin
        iv32 = 1'b1; a32 = pick32(); b32 = pick32();
        cin32 = $urandom_range(0, 1); op32 = $urandom_range(0, 1); sat32 = $urandom_range(0, 1);
      end else iv32 = 1'b0;
      #1;
      if (ov32 && !or32) stalls++;
      if (ov32 && or32) begin
        if (q_exp.size() == 0) chk("rnd_spurious", ov32, 1'b0);
        else begin
          e  = q_exp.pop_front();
          c0 = q_cyc.pop_front();
          s0 = q_stl.pop_front();
          chk("rnd", {of32, co32, sum32}, e);
          if (s0 == stalls) chk("rnd_lat", cyc - c0, 4);
          got++;
        end
      end
      if (iv32 && ir32) begin
        q_exp.push_back(mdl32(a32, b32, cin32, op32, sat32));
        q_cyc.push_back(cyc);
        q_stl.push_back(stalls);
        sent++;
      end
    end
    iv32 = 1'b0; or32 = 1'b1;
    chk("rnd_done", got, NTX);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
